fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch path: FSM states, buffered entry, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte address to ROM word index.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit boundary: ROM read port, redirect request and decode-side handshake.
// Latency: n/a (wiring only).
// Backpressure: inst_ready from decode stalls the head entry.
interface fetch_if;
  logic        en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;

  // Fetch unit side.
  modport master (
    input  en, rom_data, redirect_valid, redirect_pc, inst_ready,
    output rom_addr, inst_valid, inst, inst_pc, halted
  );

  // Environment side: ROM, branch unit and decode.
  modport slave (
    output en, rom_data, redirect_valid, redirect_pc, inst_ready,
    input  rom_addr, inst_valid, inst, inst_pc, halted
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with synchronous flush.
// Latency: an entry pushed on an edge is visible at the head from the next cycle.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_dat,
  output fetch_entry_t                 o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  // A push into a full buffer is legal only when the head leaves this cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Storage, pointers and occupancy; flush discards everything including a same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_dat;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns the PC, reads one ROM word per cycle, buffers for decode.
// Latency: first push in the first FETCH cycle, inst_valid the cycle after (3rd cycle from reset release).
// Backpressure: inst_ready low fills the buffer, then the PC stalls until a slot frees.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_WORDS  = 16,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

  fetch_state_t   r_state;
  logic [31:0]    r_pc;
  logic           r_halted;

  fetch_entry_t   w_head;
  fetch_entry_t   w_new;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic           w_pop;
  logic           w_flush;
  logic           w_past_end;
  logic           w_push_ok;
  logic           w_push;
  logic [31:0]    w_redirect_pc;

  assign bus.rom_addr   = word_index(r_pc);
  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_head.instr;
  assign bus.inst_pc    = w_head.pc;
  assign bus.halted     = r_halted;

  assign w_pop         = bus.inst_valid && bus.inst_ready;
  assign w_flush       = bus.redirect_valid && (r_state != IDLE);
  assign w_redirect_pc = bus.redirect_pc & ~32'd3;
  assign w_past_end    = (word_index(r_pc) >= ROM_LIMIT);

  // A full buffer still accepts a new word when the head drains in the same cycle.
  assign w_push_ok = (w_count < CW'(FIFO_DEPTH)) || (w_full && w_pop);

  // The end-of-image check wins over the push, so the PC never walks past the ROM.
  assign w_push = (r_state == FETCH) && !bus.redirect_valid && bus.en
                  && !w_past_end && w_push_ok;

  assign w_new.pc    = r_pc;
  assign w_new.instr = bus.rom_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_dat   (w_new),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Fetch FSM with PC and halted flag; a redirect overrides everything outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (w_flush) begin
      r_state  <= FETCH;
      r_pc     <= w_redirect_pc;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
          if (bus.en) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (bus.en && w_past_end) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model checked every cycle.
// Latency: n/a.
// Backpressure: exercised through inst_ready and en.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  fetch_if bus();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .ROM_WORDS  (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    if (idx == 32'd0)      return 32'h0020_80B3;
    else if (idx < 32'd7)  return 32'h0010_0000 | idx;
    else if (idx < 32'd16) return 32'h0030_8093;
    else                   return 32'hDEAD_BEEF;
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: expected entries queued when a fetch is predicted, popped when decode takes one.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc   = 32'd0;
  fetch_state_t m_st   = IDLE;
  logic         m_halt = 1'b0;
  bit           seen40 = 1'b0;

  always @(negedge clk) begin
    bit           pop;
    bit           ok;
    fetch_entry_t e;
    if (rst) begin
      mq.delete();
      m_pc   = 32'd0;
      m_st   = IDLE;
      m_halt = 1'b0;
    end else begin
      chk("mon_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("mon_inst_pc", bus.inst_pc, mq[0].pc);
        chk("mon_inst", bus.inst, mq[0].instr);
      end
      chk("mon_halted", 32'(bus.halted), 32'(m_halt));
      chk("mon_rom_addr", bus.rom_addr, {2'b00, m_pc[31:2]});
      if (bus.inst_valid && bus.inst_pc == 32'h40) seen40 = 1'b1;

      pop = (mq.size() != 0) && bus.inst_ready;
      ok  = (mq.size() < 2) || pop;
      if (m_st != IDLE && bus.redirect_valid) begin
        mq.delete();
        m_pc   = {bus.redirect_pc[31:2], 2'b00};
        m_st   = FETCH;
        m_halt = 1'b0;
      end else begin
        if (pop) void'(mq.pop_front());
        case (m_st)
          IDLE: begin
            if (bus.redirect_valid) m_pc = {bus.redirect_pc[31:2], 2'b00};
            if (bus.en) m_st = FETCH;
          end
          FETCH: begin
            if (bus.en) begin
              if (m_pc[31:2] >= 30'd16) begin
                m_st   = HALT;
                m_halt = 1'b1;
              end else if (ok) begin
                e.pc    = m_pc;
                e.instr = rom_word({2'b00, m_pc[31:2]});
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic do_reset(input logic ready);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.en = 1'b1;
    bus.inst_ready = ready;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;

    // Reset values.
    @(negedge clk);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_rom_addr", bus.rom_addr, 32'd0);

    // First fetch latency and streaming.
    @(posedge clk); #1;
    rst = 1'b0;
    bus.en = 1'b1;
    @(negedge clk); chk("lat_c1_valid", 32'(bus.inst_valid), 32'd0);
    @(negedge clk); chk("lat_c2_valid", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    chk("lat_c3_valid", 32'(bus.inst_valid), 32'd1);
    chk("lat_c3_inst", bus.inst, 32'h0020_80B3);
    chk("lat_c3_pc", bus.inst_pc, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("stream_valid", 32'(bus.inst_valid), 32'd1);
      chk("stream_pc", bus.inst_pc, 32'(4 * k));
    end
    chk("stream_word7", bus.inst, 32'h0030_8093);

    // Backpressure: decode stalled from reset through the 5th cycle of valid data.
    do_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("bp_c3_valid", 32'(bus.inst_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rom_addr_frozen", bus.rom_addr, 32'd2);
      chk("bp_inst_held", bus.inst, 32'h0020_80B3);
      chk("bp_pc_held", bus.inst_pc, 32'd0);
    end
    @(posedge clk); #1;
    bus.inst_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("bp_drain_pc", bus.inst_pc, 32'(4 * j));
    end

    // Redirect to an unaligned target with two entries buffered.
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h23;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid_low", 32'(bus.inst_valid), 32'd0);
    chk("redir_rom_addr", bus.rom_addr, 32'd8);
    @(negedge clk);
    chk("redir_valid", 32'(bus.inst_valid), 32'd1);
    chk("redir_pc", bus.inst_pc, 32'h20);
    chk("redir_inst", bus.inst, 32'h0030_8093);

    // Run off the end of the ROM image.
    cyc = 0;
    while (bus.rom_addr !== 32'd16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_reach_pc40", 32'(cyc < 40), 32'd1);
    chk("halt_not_yet", 32'(bus.halted), 32'd0);
    chk("halt_last_pc", bus.inst_pc, 32'h3C);
    @(negedge clk);
    chk("halt_set", 32'(bus.halted), 32'd1);
    chk("halt_rom_addr", bus.rom_addr, 32'd16);
    chk("halt_drained", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("halt_still_empty", 32'(bus.inst_valid), 32'd0);
    chk("halt_no_pc40", 32'(seen40), 32'd0);

    // Redirect out of HALT back to word 0.
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("resume_halted_clr", 32'(bus.halted), 32'd0);
    chk("resume_rom_addr", bus.rom_addr, 32'd0);
    @(negedge clk);
    chk("resume_valid", 32'(bus.inst_valid), 32'd1);
    chk("resume_pc", bus.inst_pc, 32'd0);
    chk("resume_inst", bus.inst, 32'h0020_80B3);

    // Fetch enable dropped for three cycles mid-stream.
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    bus.en = 1'b0;
    @(negedge clk);
    chk("en_e1_rom_addr", bus.rom_addr, 32'd4);
    chk("en_e1_pc", bus.inst_pc, 32'd12);
    @(negedge clk);
    chk("en_e2_rom_addr", bus.rom_addr, 32'd4);
    chk("en_e2_valid", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    chk("en_e3_rom_addr", bus.rom_addr, 32'd4);
    @(posedge clk); #1;
    bus.en = 1'b1;
    @(negedge clk);
    chk("en_e4_valid", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    chk("en_e5_valid", 32'(bus.inst_valid), 32'd1);
    chk("en_e5_pc", bus.inst_pc, 32'd16);
    chk("en_e5_rom_addr", bus.rom_addr, 32'd5);

    // Asynchronous reset mid-cycle while the buffer is full.
    @(posedge clk); #1;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_valid", 32'(bus.inst_valid), 32'd1);
    chk("arst_pre_pc", bus.inst_pc, 32'h14);
    chk("arst_pre_rom_addr", bus.rom_addr, 32'd7);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.inst_valid), 32'd0);
    chk("arst_halted", 32'(bus.halted), 32'd0);
    chk("arst_rom_addr", bus.rom_addr, 32'd0);
    chk("arst_inst", bus.inst, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
